// File: rtl/defines.sv
// rtl/defines.sv - shared RV32I pipeline parameters
package defines;
    localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/pc_select.sv
// rtl/pc_select.sv - Fetch next-PC mux with misalign flag and redirect tracking
// Optional PC_SEL_STATS_EN builds the saturating taken-redirect counter.
module pc_select
    import defines::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_plus4_i,
    input  logic [DATA_WIDTH-1:0] branch_target_addr_i,
    input  logic                  PCSrc_i,
    output logic [DATA_WIDTH-1:0] pc_sel_o,
    output logic                  misalign_o,
    output logic                  redirect_q_o,
    output logic [31:0]           redirect_cnt_o
);

    logic w_target_misaligned;
    logic r_redirect_q;

    // Select path stays purely combinational and ignores rst.
    assign w_target_misaligned = (branch_target_addr_i[1:0] != 2'b00);
    assign pc_sel_o            = PCSrc_i ? branch_target_addr_i : pc_plus4_i;
    assign misalign_o          = PCSrc_i & w_target_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_q <= 1'b0;
        end else begin
            r_redirect_q <= PCSrc_i;
        end
    end

    assign redirect_q_o = r_redirect_q;

`ifdef PC_SEL_STATS_EN
    logic [31:0] r_redirect_cnt;

    // Saturates so a long run never reports a small wrapped count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_cnt <= 32'h0;
        end else if (PCSrc_i && (r_redirect_cnt != 32'hFFFF_FFFF)) begin
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end

    assign redirect_cnt_o = r_redirect_cnt;
`else
    assign redirect_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pc_select.sv
// tb/tb_pc_select.sv - scoreboard bench for pc_select (PC_SEL_STATS_EN aware)
module tb_pc_select;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        mis;
        logic        rq;
        logic [31:0] cnt;
    } exp_t;

`ifdef PC_SEL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_plus4_i;
    logic [31:0] branch_target_addr_i;
    logic        PCSrc_i;
    logic [31:0] pc_sel_o;
    logic        misalign_o;
    logic        redirect_q_o;
    logic [31:0] redirect_cnt_o;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pc_select dut (
        .clk                  (clk),
        .rst                  (rst),
        .pc_plus4_i           (pc_plus4_i),
        .branch_target_addr_i (branch_target_addr_i),
        .PCSrc_i              (PCSrc_i),
        .pc_sel_o             (pc_sel_o),
        .misalign_o           (misalign_o),
        .redirect_q_o         (redirect_q_o),
        .redirect_cnt_o       (redirect_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cnt_e(input logic [31:0] v);
        return STATS ? v : 32'h0;
    endfunction

    task automatic drive(input logic [31:0] p4, input logic [31:0] tgt, input logic src);
        pc_plus4_i           = p4;
        branch_target_addr_i = tgt;
        PCSrc_i              = src;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_now(input string nm, input logic [31:0] pc, input logic mis,
                              input logic rq, input logic [31:0] cnt);
        exp_t e;
        #1;
        e.name = nm;
        e.pc   = pc;
        e.mis  = mis;
        e.rq   = rq;
        e.cnt  = cnt;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: outputs are held stable while an entry is pending.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            checks++;
            if (pc_sel_o !== e.pc) begin
                errors++;
                $display("FAIL %s pc_sel_o: got %h expected %h", e.name, pc_sel_o, e.pc);
            end
            checks++;
            if (misalign_o !== e.mis) begin
                errors++;
                $display("FAIL %s misalign_o: got %b expected %b", e.name, misalign_o, e.mis);
            end
            checks++;
            if (redirect_q_o !== e.rq) begin
                errors++;
                $display("FAIL %s redirect_q_o: got %b expected %b", e.name, redirect_q_o, e.rq);
            end
            checks++;
            if (redirect_cnt_o !== e.cnt) begin
                errors++;
                $display("FAIL %s redirect_cnt_o: got %h expected %h", e.name, redirect_cnt_o, e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(32'h100, 32'h200, 1'b0);
        @(negedge clk);
        tick();
        tick();
        expect_now("reset_seq", 32'h100, 1'b0, 1'b0, 32'h0);

        rst = 1'b0;
        tick();
        expect_now("idle_seq", 32'h100, 1'b0, 1'b0, cnt_e(0));

        drive(32'h300, 32'h400, 1'b1);
        expect_now("take_comb", 32'h400, 1'b0, 1'b0, cnt_e(0));
        tick();
        expect_now("take_reg", 32'h400, 1'b0, 1'b1, cnt_e(1));

        drive(32'h500, 32'h500, 1'b0);
        expect_now("equal_src0", 32'h500, 1'b0, 1'b1, cnt_e(1));
        drive(32'h500, 32'h500, 1'b1);
        expect_now("equal_src1", 32'h500, 1'b0, 1'b1, cnt_e(1));
        tick();
        expect_now("equal_reg", 32'h500, 1'b0, 1'b1, cnt_e(2));

        drive(32'h500, 32'h402, 1'b1);
        expect_now("misalign_on", 32'h402, 1'b1, 1'b1, cnt_e(2));
        drive(32'h500, 32'h402, 1'b0);
        expect_now("misalign_off", 32'h500, 1'b0, 1'b1, cnt_e(2));
        tick();
        expect_now("seq_reg", 32'h500, 1'b0, 1'b0, cnt_e(2));

        rst = 1'b1;
        tick();
        tick();
        expect_now("rst_mid", 32'h500, 1'b0, 1'b0, 32'h0);
        drive(32'h104, 32'h402, 1'b1);
        expect_now("rst_comb", 32'h402, 1'b1, 1'b0, 32'h0);
        tick();
        expect_now("rst_wins", 32'h402, 1'b1, 1'b0, 32'h0);

        rst = 1'b0;
        drive(32'h104, 32'h400, 1'b1);
        tick();
        expect_now("cnt_1", 32'h400, 1'b0, 1'b1, cnt_e(1));
        tick();
        tick();
        expect_now("cnt_3", 32'h400, 1'b0, 1'b1, cnt_e(3));
        drive(32'h104, 32'h400, 1'b0);
        tick();
        expect_now("cnt_hold", 32'h104, 1'b0, 1'b0, cnt_e(3));

`ifdef PC_SEL_STATS_EN
        force dut.r_redirect_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_redirect_cnt;
`endif
        drive(32'h108, 32'h800, 1'b1);
        tick();
        expect_now("sat_1", 32'h800, 1'b0, 1'b1, STATS ? 32'hFFFF_FFFF : 32'h0);
        tick();
        tick();
        expect_now("sat_3", 32'h800, 1'b0, 1'b1, STATS ? 32'hFFFF_FFFF : 32'h0);
        rst = 1'b1;
        tick();
        expect_now("sat_rst", 32'h800, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
